// File: rtl/fcc_pkg.sv
// fcc_pkg: shared widths, image geometry and scan FSM encoding
// for range_img_streamer and its window counter.
package fcc_pkg;

  localparam int W     = 16;
  localparam int ROWS  = 64;
  localparam int COLS  = 900;
  localparam int ROW_W = 8;
  localparam int COL_W = 10;
  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CHK  = 3'd2,
    S_EMIT = 3'd3,
    S_FIN  = 3'd4
  } state_t;

endpackage

// File: rtl/range_img_streamer_if.sv
// range_img_streamer_if: valid/ready point stream (row, col, x/y/z,
// ground flag). master = producer, slave = consumer.
interface range_img_streamer_if
  import fcc_pkg::*;
#(
  parameter int W     = fcc_pkg::W,
  parameter int ROW_W = fcc_pkg::ROW_W,
  parameter int COL_W = fcc_pkg::COL_W
);

  logic                valid;
  logic                ready;
  logic [ROW_W-1:0]    row;
  logic [COL_W-1:0]    col;
  logic signed [W-1:0] x;
  logic signed [W-1:0] y;
  logic signed [W-1:0] z;
  logic                is_ground;

  modport master (
    output valid, row, col, x, y, z, is_ground,
    input  ready
  );

  modport slave (
    input  valid, row, col, x, y, z, is_ground,
    output ready
  );

endinterface

// File: rtl/rimg_scan_ctr.sv
// rimg_scan_ctr: row-major window walker. load captures the window and
// starts at (row0,col0); adv steps; last flags the final (row1,col1) cell.
module rimg_scan_ctr
  import fcc_pkg::*;
#(
  parameter int ROW_W = fcc_pkg::ROW_W,
  parameter int COL_W = fcc_pkg::COL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             adv,
  input  logic [ROW_W-1:0] row0,
  input  logic [ROW_W-1:0] row1,
  input  logic [COL_W-1:0] col0,
  input  logic [COL_W-1:0] col1,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             last
);

  logic [ROW_W-1:0] row1_q;
  logic [COL_W-1:0] col0_q;
  logic [COL_W-1:0] col1_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row    <= '0;
      col    <= '0;
      row1_q <= '0;
      col0_q <= '0;
      col1_q <= '0;
    end else if (load) begin
      row    <= row0;
      col    <= col0;
      row1_q <= row1;
      col0_q <= col0;
      col1_q <= col1;
    end else if (adv) begin
      if (col == col1_q) begin
        col <= col0_q;
        row <= row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  assign last = (row == row1_q) && (col == col1_q);

endmodule

// File: rtl/range_img_streamer.sv
// range_img_streamer: scans a row/col window of a range image memory,
// drops all-zero points and streams the rest over out_if (master).
// Ports: clk, rst (async, active-low), start + cfg_* window/cap/ground,
// busy/done/err/sent_cnt status, mem_rd_* one-cycle read port, out_if.
// Build option GROUND_FLAG_EN: out_is_ground = (out_z <= cfg_ground_z).
module range_img_streamer
  import fcc_pkg::*;
#(
  parameter int W     = fcc_pkg::W,
  parameter int ROWS  = fcc_pkg::ROWS,
  parameter int COLS  = fcc_pkg::COLS,
  parameter int ROW_W = fcc_pkg::ROW_W,
  parameter int COL_W = fcc_pkg::COL_W,
  parameter int CNT_W = fcc_pkg::CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ROW_W-1:0]    cfg_row0,
  input  logic [ROW_W-1:0]    cfg_row1,
  input  logic [COL_W-1:0]    cfg_col0,
  input  logic [COL_W-1:0]    cfg_col1,
  input  logic [CNT_W-1:0]    cfg_max_pts,
  input  logic signed [W-1:0] cfg_ground_z,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [CNT_W-1:0]    sent_cnt,
  output logic                mem_rd_en,
  output logic [ROW_W-1:0]    mem_rd_row,
  output logic [COL_W-1:0]    mem_rd_col,
  input  logic signed [W-1:0] mem_rd_x,
  input  logic signed [W-1:0] mem_rd_y,
  input  logic signed [W-1:0] mem_rd_z,
  range_img_streamer_if.master out_if
);

  state_t state;
  state_t state_nx;

  logic                accept;
  logic                win_bad;
  logic                go_rd;
  logic                pt_zero;
  logic                xfer;
  logic                cap_hit;
  logic                last;
  logic                adv;
  logic [CNT_W-1:0]    max_q;

  logic [ROW_W-1:0]    row_q;
  logic [COL_W-1:0]    col_q;
  logic signed [W-1:0] x_q;
  logic signed [W-1:0] y_q;
  logic signed [W-1:0] z_q;

  assign accept  = (state == S_IDLE) && start;
  assign win_bad = (cfg_row0 > cfg_row1) ||
                   (cfg_col0 > cfg_col1) ||
                   (int'(cfg_row1) >= ROWS) ||
                   (int'(cfg_col1) >= COLS);
  assign go_rd   = accept && !win_bad && (cfg_max_pts != '0);
  assign pt_zero = (mem_rd_x == '0) &&
                   (mem_rd_y == '0) &&
                   (mem_rd_z == '0);
  assign xfer    = (state == S_EMIT) && out_if.ready;
  // the transfer in flight is the one that reaches the cap
  assign cap_hit = (sent_cnt + CNT_W'(1)) == max_q;
  assign adv     = ((state == S_CHK) && pt_zero && !last) ||
                   (xfer && !cap_hit && !last);

  rimg_scan_ctr #(
    .ROW_W (ROW_W),
    .COL_W (COL_W)
  ) u_ctr (
    .clk  (clk),
    .rst  (rst),
    .load (go_rd),
    .adv  (adv),
    .row0 (cfg_row0),
    .row1 (cfg_row1),
    .col0 (cfg_col0),
    .col1 (cfg_col1),
    .row  (mem_rd_row),
    .col  (mem_rd_col),
    .last (last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (accept) state_nx = go_rd ? S_RD : S_FIN;
      end
      S_RD: state_nx = S_CHK;
      S_CHK: begin
        if (!pt_zero)  state_nx = S_EMIT;
        else if (last) state_nx = S_FIN;
        else           state_nx = S_RD;
      end
      S_EMIT: begin
        if (xfer) state_nx = (cap_hit || last) ? S_FIN : S_RD;
      end
      S_FIN:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy         = 1'b0;
    done         = 1'b0;
    mem_rd_en    = 1'b0;
    out_if.valid = 1'b0;
    unique case (1'b1)
      state == S_RD: begin
        busy      = 1'b1;
        mem_rd_en = 1'b1;
      end
      state == S_CHK: busy = 1'b1;
      state == S_EMIT: begin
        busy         = 1'b1;
        out_if.valid = 1'b1;
      end
      state == S_FIN: done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err      <= 1'b0;
      sent_cnt <= '0;
      max_q    <= '0;
      row_q    <= '0;
      col_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
    end else begin
      if (accept) begin
        err      <= win_bad;
        sent_cnt <= '0;
        max_q    <= cfg_max_pts;
      end
      if ((state == S_CHK) && !pt_zero) begin
        row_q <= mem_rd_row;
        col_q <= mem_rd_col;
        x_q   <= mem_rd_x;
        y_q   <= mem_rd_y;
        z_q   <= mem_rd_z;
      end
      if (xfer) sent_cnt <= sent_cnt + CNT_W'(1);
    end
  end

`ifdef GROUND_FLAG_EN
  logic signed [W-1:0] gz_q;
  logic                gnd_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gz_q  <= '0;
      gnd_q <= 1'b0;
    end else begin
      if (accept) gz_q <= cfg_ground_z;
      if ((state == S_CHK) && !pt_zero)
        gnd_q <= (mem_rd_z <= gz_q);
    end
  end

  assign out_if.is_ground = gnd_q;
`else
  logic unused_gz;

  assign unused_gz        = ^cfg_ground_z;
  assign out_if.is_ground = 1'b0;
`endif

  assign out_if.row = row_q;
  assign out_if.col = col_q;
  assign out_if.x   = x_q;
  assign out_if.y   = y_q;
  assign out_if.z   = z_q;

endmodule

// File: doc/range_img_streamer.md
RANGE_IMG_STREAMER -- requirements
Module: range_img_streamer

Interface
REQ-001 Parameters: W=16 coordinate width; ROWS=64; COLS=900; ROW_W=8; COL_W=10; CNT_W=16 point-counter width.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 start  in  1  one-cycle scan request; ignored while busy=1.
REQ-005 cfg_row0/cfg_row1  in  ROW_W each  inclusive row window; cfg_col0/cfg_col1  in  COL_W each  inclusive column window.
REQ-006 cfg_max_pts  in  CNT_W  emitted-point cap; cfg_ground_z  in  W signed  ground height threshold.
REQ-007 busy  out  1  scan in progress; done  out  1  one-cycle completion pulse; err  out  1  invalid-window flag; sent_cnt  out  CNT_W  points emitted by last scan.
REQ-008 mem_rd_en  out  1; mem_rd_row  out  ROW_W; mem_rd_col  out  COL_W; mem_rd_x/y/z  in  W signed each, valid exactly one cycle after mem_rd_en.
REQ-009 out_valid  out  1; out_ready  in  1; out_row  out  ROW_W; out_col  out  COL_W; out_x/y/z  out  W signed each; out_is_ground  out  1.

Function
REQ-010 cfg_* shall be captured on the accepted start cycle; later changes shall not affect a running scan.
REQ-011 FSM states IDLE, RD, CHK, EMIT, FIN; IDLE->RD on accepted start (valid window), RD->CHK always, CHK->EMIT on non-zero point, CHK->RD/FIN on zero point, EMIT->RD/FIN on out_valid&&out_ready, FIN->IDLE always.
REQ-012 RD: mem_rd_en=1 with current (row,col) for exactly one cycle; start accepted at cycle T gives mem_rd_en at T+1, earliest out_valid at T+3.
REQ-013 CHK: point with x=y=z=0 shall be skipped (no emit); otherwise output registers load row, col, x, y, z.
REQ-014 EMIT: out_valid held high and all out_* held stable until out_ready=1; transfer occurs on the cycle both are high.
REQ-015 Scan order row-major: col increments to cfg_col1, then wraps to cfg_col0 with row+1; after (cfg_row1,cfg_col1) processed -> FIN.
REQ-016 sent_cnt increments on each transfer; reaching cfg_max_pts shall go to FIN immediately after that transfer; cfg_max_pts=0 shall go IDLE->FIN with no reads.
REQ-017 Invalid window (row0>row1, col0>col1, row1>=ROWS or col1>=COLS) shall go IDLE->FIN with err=1, no reads; err clears on next accepted start.
REQ-018 FIN: done=1 for one cycle, busy=0 in that cycle; busy=1 in RD, CHK, EMIT.
REQ-019 sent_cnt cleared on accepted start, held after FIN until next start.
REQ-020 start asserted in the FIN cycle shall be ignored.

Reset
REQ-021 rst low shall immediately force IDLE, and busy, done, err, out_valid, mem_rd_en, sent_cnt, out_* to 0, including mid-scan or mid-EMIT; no transfer completes during reset.

Configuration
REQ-022 Macro GROUND_FLAG_EN defined: out_is_ground = (out_z <= cfg_ground_z), signed compare, registered with the point in CHK.
REQ-023 GROUND_FLAG_EN undefined: out_is_ground constant 0; cfg_ground_z port present but ignored.

Structure
REQ-024 Package fcc_pkg holds W, ROW_W, COL_W, CNT_W, ROWS, COLS defaults and the FSM state encoding, shared with fcc_top.
REQ-025 Sub-module rimg_scan_ctr holds the row/column window counter (load, advance, last flag); FSM, output register and point counter stay in the top.

Verification
REQ-026 Window rows 0..4, cols 0..59, all points non-zero, cap 300, out_ready=1 -> exactly 300 transfers in row-major order, sent_cnt=300, one done pulse.
REQ-027 Same window, cap 1000, every odd column zero -> 150 transfers, even columns only, no out_valid for zero points.
REQ-028 out_ready toggling 1-of-3 cycles -> out_* stable while out_valid&&!out_ready, no duplicated or lost point vs. golden list.
REQ-029 cfg_col0=10, cfg_col1=5 -> no mem_rd_en, done one cycle after start, err=1, sent_cnt=0; cfg_max_pts=0 -> same with err=0.
REQ-030 rst low during EMIT of third point -> all outputs 0 next edge; fresh start rescans from cfg_row0/cfg_col0 with sent_cnt from 0.
REQ-031 GROUND_FLAG_EN defined, cfg_ground_z=-1500, points z=-2000/-1500/0 -> out_is_ground 1/1/0; undefined -> 0/0/0.
